// File: rtl/mips_seq_shifter.sv
// Multicycle shift/rotate unit: accepts one operation when idle, walks the
// operand at most STEP bit positions per cycle, then pulses done for one cycle.
module mips_seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [WIDTH-1:0]   result
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] F_PASS = 3'd0;
    localparam logic [2:0] F_SLL  = 3'd1;
    localparam logic [2:0] F_SRL  = 3'd2;
    localparam logic [2:0] F_SRA  = 3'd3;
    localparam logic [2:0] F_ROL  = 3'd4;
    localparam logic [2:0] F_ROR  = 3'd5;

    // One extra bit so that STEP == WIDTH is representable.
    localparam logic [SHAMT_W:0] STEP_W  = (SHAMT_W+1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_W = (SHAMT_W+1)'(WIDTH);

    logic [1:0]         state_reg, state_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic [2:0]         funct_reg, funct_next;
    logic [SHAMT_W-1:0] remaining_reg, remaining_next;
    logic               sign_reg, sign_next;
    logic               illegal_reg, illegal_next;

    logic [SHAMT_W-1:0] step_amt;
    logic [SHAMT_W:0]   rot_back;
    logic [WIDTH-1:0]   fill_mask;
    logic [WIDTH-1:0]   shifted;
    logic               shift_op;

    // Per-cycle step: k = min(STEP, remaining). k never exceeds WIDTH-1, so
    // the complementary rotate amount WIDTH-k stays within the word.
    always_comb begin
        step_amt  = ({1'b0, remaining_reg} > STEP_W) ? STEP_W[SHAMT_W-1:0] : remaining_reg;
        rot_back  = WIDTH_W - {1'b0, step_amt};
        fill_mask = ~({WIDTH{1'b1}} >> step_amt);
        case (funct_reg)
            F_SLL:   shifted = result_reg << step_amt;
            F_SRL:   shifted = result_reg >> step_amt;
            F_SRA:   shifted = (result_reg >> step_amt) | (fill_mask & {WIDTH{sign_reg}});
            F_ROL:   shifted = (result_reg << step_amt) | (result_reg >> rot_back);
            F_ROR:   shifted = (result_reg >> step_amt) | (result_reg << rot_back);
            default: shifted = result_reg;
        endcase
    end

    assign shift_op = (funct != F_PASS) && (funct[2:1] != 2'b11);

    always_comb begin
        state_next     = state_reg;
        result_next    = result_reg;
        funct_next     = funct_reg;
        remaining_next = remaining_reg;
        sign_next      = sign_reg;
        illegal_next   = illegal_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    result_next    = data_in;
                    funct_next     = funct;
                    remaining_next = shamt;
                    sign_next      = data_in[WIDTH-1];
                    illegal_next   = (funct[2:1] == 2'b11);
                    if ((shamt == '0) || !shift_op)
                        state_next = ST_DONE;
                    else
                        state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                result_next    = shifted;
                remaining_next = remaining_reg - step_amt;
                if (remaining_reg == step_amt)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            result_reg    <= '0;
            funct_reg     <= F_PASS;
            remaining_reg <= '0;
            sign_reg      <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            result_reg    <= result_next;
            funct_reg     <= funct_next;
            remaining_reg <= remaining_next;
            sign_reg      <= sign_next;
            illegal_reg   <= illegal_next;
        end
    end

    // Outputs decode registered state only; nothing flows straight from inputs.
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign illegal = (state_reg == ST_DONE) && illegal_reg;
    assign result  = result_reg;

endmodule
